branch_predictor: RTL and testbench

Dynamic branch predictor for the 5-stage core. It sits in fetch, where it predicts taken/not-taken and the target for the current fetch PC. Execute-stage branch resolution feeds the actual outcome back to train the predictor. The predictor flags a mispredict with the corrected PC, so the hazard unit can flush and redirect.

---
 rtl/branch_pred_pkg.sv | 11 +
 rtl/branch_target_buffer.sv | 56 +++++
 rtl/branch_predictor.sv | 76 +++++++
 tb/tb_branch_predictor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// branch_pred_pkg: shared 2-bit predictor counter type and its saturating update.
package branch_pred_pkg;

    typedef enum logic [1:0] {SNT, WNT, WT, ST} pred_counter_t;

    function automatic pred_counter_t sat_update(pred_counter_t c, logic taken);
        return taken ? (c == ST  ? ST  : pred_counter_t'(c + 2'd1))
                     : (c == SNT ? SNT : pred_counter_t'(c - 2'd1));
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: flop-array BTB with an async fetch read port and an execute read-modify-write port.
module branch_target_buffer
    import branch_pred_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:2] rd_pc,
    output logic                  rd_hit,
    output logic [DATA_WIDTH-1:0] rd_target,
    output pred_counter_t         rd_counter,
    input  logic [DATA_WIDTH-1:2] ex_pc,
    output logic                  ex_hit,
    output logic [DATA_WIDTH-1:0] ex_target,
    output pred_counter_t         ex_counter,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_target,
    input  pred_counter_t         wr_counter
);
    localparam int IDX = $clog2(ENTRIES);

    logic                       valid   [ENTRIES];
    logic [DATA_WIDTH-1:IDX+2]  tag     [ENTRIES];
    logic [DATA_WIDTH-1:0]      target  [ENTRIES];
    pred_counter_t              counter [ENTRIES];
    logic [IDX-1:0]             rd_idx;
    logic [IDX-1:0]             ex_idx;

    assign rd_idx     = rd_pc[IDX+1:2];
    assign ex_idx     = ex_pc[IDX+1:2];
    assign rd_hit     = valid[rd_idx] && tag[rd_idx] == rd_pc[DATA_WIDTH-1:IDX+2];
    assign rd_target  = target[rd_idx];
    assign rd_counter = counter[rd_idx];
    assign ex_hit     = valid[ex_idx] && tag[ex_idx] == ex_pc[DATA_WIDTH-1:IDX+2];
    assign ex_target  = target[ex_idx];
    assign ex_counter = counter[ex_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tag[i]     <= '0;
                target[i]  <= '0;
                counter[i] <= WNT;
            end
        end else if (wr_en) begin
            valid[ex_idx]   <= 1'b1;
            tag[ex_idx]     <= ex_pc[DATA_WIDTH-1:IDX+2];
            target[ex_idx]  <= wr_target;
            counter[ex_idx] <= wr_counter;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage taken/target prediction trained by execute-stage branch resolution.
module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PCF,
    output logic                  PredictTakenF,
    output logic [DATA_WIDTH-1:0] PredictTargetF,
    input  logic                  UpdateE,
    input  logic                  IsJumpE,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic                  TakenE,
    input  logic [DATA_WIDTH-1:0] TargetE,
    input  logic                  PredTakenE,
    input  logic [DATA_WIDTH-1:0] PredTargetE,
    output logic                  MispredictE,
    output logic [DATA_WIDTH-1:0] RecoverPCE,
    output logic [31:0]           BranchCount,
    output logic [31:0]           MispredictCount
);
    logic                  rd_hit;
    logic                  ex_hit;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_target;
    logic [DATA_WIDTH-1:0] ex_target;
    logic [DATA_WIDTH-1:0] wr_target;
    pred_counter_t         rd_counter;
    pred_counter_t         ex_counter;
    pred_counter_t         wr_counter;

    branch_target_buffer #(.ENTRIES(ENTRIES), .DATA_WIDTH(DATA_WIDTH)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (PCF[DATA_WIDTH-1:2]),
        .rd_hit    (rd_hit),
        .rd_target (rd_target),
        .rd_counter(rd_counter),
        .ex_pc     (PCE[DATA_WIDTH-1:2]),
        .ex_hit    (ex_hit),
        .ex_target (ex_target),
        .ex_counter(ex_counter),
        .wr_en     (wr_en),
        .wr_target (wr_target),
        .wr_counter(wr_counter)
    );

    assign PredictTakenF  = rd_hit && (rd_counter == WT || rd_counter == ST);
    assign PredictTargetF = PredictTakenF ? rd_target : PCF + DATA_WIDTH'(4);
    assign MispredictE    = UpdateE && ((PredTakenE != TakenE) ||
                            (TakenE && PredTakenE && PredTargetE != TargetE));
    assign RecoverPCE     = TakenE ? TargetE : PCE + DATA_WIDTH'(4);

    // Not-taken misses never allocate; hits keep their target unless taken.
    always_comb begin
        wr_en      = UpdateE && (ex_hit || TakenE);
        wr_target  = TakenE ? TargetE : ex_target;
        wr_counter = IsJumpE ? ST : ex_hit ? sat_update(ex_counter, TakenE) : WT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else if (UpdateE) begin
            if (BranchCount != '1)
                BranchCount <= BranchCount + 32'd1;
            if (MispredictE && MispredictCount != '1)
                MispredictCount <= MispredictCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for branch_predictor.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        PredictTakenF;
    logic [31:0] PredictTargetF;
    logic        UpdateE;
    logic        IsJumpE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] RecoverPCE;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    int checks = 0;
    int errors = 0;
    int exp_bc = 0;
    int exp_mc = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    branch_predictor #(.ENTRIES(16), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .PCF            (PCF),
        .PredictTakenF  (PredictTakenF),
        .PredictTargetF (PredictTargetF),
        .UpdateE        (UpdateE),
        .IsJumpE        (IsJumpE),
        .PCE            (PCE),
        .TakenE         (TakenE),
        .TargetE        (TargetE),
        .PredTakenE     (PredTakenE),
        .PredTargetE    (PredTargetE),
        .MispredictE    (MispredictE),
        .RecoverPCE     (RecoverPCE),
        .BranchCount    (BranchCount),
        .MispredictCount(MispredictCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(string n);
        return n == "ptk" ? {31'd0, PredictTakenF} :
               n == "ptg" ? PredictTargetF :
               n == "mis" ? {31'd0, MispredictE} :
               n == "rec" ? RecoverPCE :
               n == "bc"  ? BranchCount : MispredictCount;
    endfunction

    task automatic push(input string n, input logic [31:0] v);
        sb.push_back('{n, v});
    endtask

    task automatic compare_now();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.name);
            checks++;
            assert (o === e.exp)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.name, o, e.exp);
            end
        end
    endtask

    task automatic settle_check();
        @(negedge clk);
        compare_now();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tk, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg, input logic mis, input logic [31:0] rec);
        UpdateE     = 1'b1;
        PCE         = pc;
        IsJumpE     = jmp;
        TakenE      = tk;
        TargetE     = tgt;
        PredTakenE  = pt;
        PredTargetE = ptg;
        push("mis", {31'd0, mis});
        push("rec", rec);
        settle_check();
        exp_bc++;
        if (mis) exp_mc++;
    endtask

    task automatic look(input logic [31:0] pc, input logic ptk, input logic [31:0] ptg);
        UpdateE = 1'b0;
        PCF     = pc;
        push("ptk", {31'd0, ptk});
        push("ptg", ptg);
        push("bc", exp_bc);
        push("mc", exp_mc);
        settle_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; PCF = 32'h100; UpdateE = 1'b0; IsJumpE = 1'b0; PCE = '0;
        TakenE = 1'b0; TargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
        #3;
        push("ptk", 0); push("ptg", 32'h104); push("bc", 0); push("mc", 0);
        push("mis", 0); push("rec", 32'h4);
        compare_now();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        look(32'h100, 0, 32'h104);
        // allocation, with same-cycle lookup still seeing the old contents
        push("ptk", 0);
        upd(32'h100, 0, 1, 32'h80, 0, 32'h104, 1, 32'h80);
        look(32'h100, 1, 32'h80);
        // hysteresis
        upd(32'h100, 0, 1, 32'h80, 1, 32'h80, 0, 32'h80);
        upd(32'h100, 0, 1, 32'h80, 1, 32'h80, 0, 32'h80);
        upd(32'h100, 0, 0, 32'h80, 1, 32'h80, 1, 32'h104);
        look(32'h100, 1, 32'h80);
        upd(32'h100, 0, 0, 32'h80, 1, 32'h80, 1, 32'h104);
        look(32'h100, 0, 32'h104);
        upd(32'h100, 0, 0, 32'h0, 0, 32'h104, 0, 32'h104);
        upd(32'h100, 0, 1, 32'h80, 0, 32'h104, 1, 32'h80);
        look(32'h100, 0, 32'h104);
        // aliasing and no allocation on not-taken miss
        upd(32'h140, 0, 1, 32'h60, 0, 32'h144, 1, 32'h60);
        look(32'h100, 0, 32'h104);
        look(32'h140, 1, 32'h60);
        upd(32'h180, 0, 0, 32'h0, 0, 32'h184, 0, 32'h184);
        look(32'h140, 1, 32'h60);
        look(32'h180, 0, 32'h184);
        // jumps: allocate as ST, retarget, and force ST on hit
        upd(32'h200, 1, 1, 32'h340, 1, 32'h300, 1, 32'h340);
        look(32'h200, 1, 32'h340);
        upd(32'h200, 1, 1, 32'h380, 1, 32'h340, 1, 32'h380);
        look(32'h200, 1, 32'h380);
        upd(32'h200, 0, 0, 32'h0, 1, 32'h380, 1, 32'h204);
        upd(32'h200, 0, 0, 32'h0, 1, 32'h380, 1, 32'h204);
        look(32'h200, 0, 32'h204);
        upd(32'h200, 1, 1, 32'h380, 0, 32'h204, 1, 32'h380);
        upd(32'h200, 0, 0, 32'h0, 1, 32'h380, 1, 32'h204);
        look(32'h200, 1, 32'h380);
        // target-only mispredict, then a correct prediction
        upd(32'h200, 0, 1, 32'h3c0, 1, 32'h380, 1, 32'h3c0);
        look(32'h200, 1, 32'h3c0);
        upd(32'h200, 0, 1, 32'h3c0, 1, 32'h3c0, 0, 32'h3c0);
        upd(32'h104, 0, 1, 32'h10, 0, 32'h108, 1, 32'h10);
        look(32'h104, 1, 32'h10);
        look(32'h200, 1, 32'h3c0);
        // wrap-around of PC+4
        PCE = 32'hFFFF_FFFC; TakenE = 1'b0;
        push("rec", 32'h0);
        look(32'hFFFF_FFFC, 0, 32'h0);
        // asynchronous reset between edges
        PCF = 32'h200;
        #2 rst = 1'b1;
        #1;
        exp_bc = 0; exp_mc = 0;
        push("ptk", 0); push("ptg", 32'h204); push("bc", 0); push("mc", 0);
        compare_now();
        // update held across an edge while in reset must not write
        UpdateE = 1'b1; IsJumpE = 1'b0; PCE = 32'h300; TakenE = 1'b1; TargetE = 32'h500; PredTakenE = 1'b0;
        @(posedge clk); #1;
        UpdateE = 1'b0; rst = 1'b0;
        look(32'h300, 0, 32'h304);
        look(32'h200, 0, 32'h204);
        look(32'h104, 0, 32'h108);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
